m3_power_seq: RTL and testbench

M3_POWER_SEQ -- requirements
Module: m3_power_seq

---
 rtl/m3_power_seq_pkg.sv | 62 ++++++
 rtl/m3_power_seq_if.sv | 42 ++++
 rtl/pwr_seq_timer.sv | 32 +++
 rtl/m3_power_seq.sv | 157 +++++++++++++++
 tb/tb_m3_power_seq.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m3_power_seq_pkg.sv
// m3_power_seq_pkg: shared types and constants for the M3 power sequencer.
//   state_t     : sequencer states (ST_REL only with M3_PWR_SEQ_RESET_EN)
//   rails_t     : the three rail enables as one packed word
//   DLY_RST_DEF : default step delay after reset (clk cycles)
//   rails_of()  : rail enables owned by each state
//   is_idle()   : OFF and ON are the only non-sequencing states
// Optional feature macro: M3_PWR_SEQ_RESET_EN
package m3_power_seq_pkg;

    localparam logic [15:0] DLY_RST_DEF = 16'd1000;

`ifdef M3_PWR_SEQ_RESET_EN
    typedef enum logic [3:0] {
        ST_OFF, ST_UP_VB, ST_UP_12, ST_UP_06, ST_REL,
        ST_ON, ST_DN_06, ST_DN_12, ST_DN_VB
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_OFF, ST_UP_VB, ST_UP_12, ST_UP_06,
        ST_ON, ST_DN_06, ST_DN_12, ST_DN_VB
    } state_t;
`endif

    typedef struct packed {
        logic vbatt;
        logic v1p2;
        logic v0p6;
    } rails_t;

    // Rails are a pure function of state, so the ordering
    // 0P6 -> 1P2 -> VBATT holds by construction in every state.
    function automatic rails_t rails_of(input state_t s);
        rails_t r;
        r = '0;
        case (s)
            ST_UP_VB, ST_DN_12: begin
                r.vbatt = 1'b1;
            end
            ST_UP_12, ST_DN_06: begin
                r.vbatt = 1'b1;
                r.v1p2  = 1'b1;
            end
            ST_UP_06, ST_ON: begin
                r = '1;
            end
`ifdef M3_PWR_SEQ_RESET_EN
            ST_REL: begin
                r = '1;
            end
`endif
            default: begin
                r = '0;
            end
        endcase
        return r;
    endfunction

    function automatic logic is_idle(input state_t s);
        return (s == ST_OFF) || (s == ST_ON);
    endfunction

endpackage

// File: rtl/m3_power_seq_if.sv
// m3_power_seq_if: request/config/status bundle of the M3 power sequencer.
//   pwr_on_req, pwr_off_req : single-cycle request pulses
//   cfg_we, cfg_dly         : step-delay register write
//   vbatt_sw, v1p2_sw, v0p6_sw : rail enables (1 = on)
//   busy, pwr_good, done    : sequencer status
//   m3_reset                : M3 core reset (only with M3_PWR_SEQ_RESET_EN)
// master = requester side, slave = sequencer side.
interface m3_power_seq_if #(
    parameter int unsigned DLY_W = 16
) ();

    logic             pwr_on_req;
    logic             pwr_off_req;
    logic             cfg_we;
    logic [DLY_W-1:0] cfg_dly;
    logic             vbatt_sw;
    logic             v1p2_sw;
    logic             v0p6_sw;
    logic             busy;
    logic             pwr_good;
    logic             done;
`ifdef M3_PWR_SEQ_RESET_EN
    logic             m3_reset;
`endif

    modport master (
        output pwr_on_req, pwr_off_req, cfg_we, cfg_dly,
`ifdef M3_PWR_SEQ_RESET_EN
        input  m3_reset,
`endif
        input  vbatt_sw, v1p2_sw, v0p6_sw, busy, pwr_good, done
    );

    modport slave (
        input  pwr_on_req, pwr_off_req, cfg_we, cfg_dly,
`ifdef M3_PWR_SEQ_RESET_EN
        output m3_reset,
`endif
        output vbatt_sw, v1p2_sw, v0p6_sw, busy, pwr_good, done
    );

endinterface

// File: rtl/pwr_seq_timer.sv
// pwr_seq_timer: step-delay down-counter.
//   clk, reset : system clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle
//   load_val   : step delay D
//   zero       : count is 0 (last cycle of the current step)
// The count holds at 0 instead of wrapping, so a full-scale D runs its
// whole length and an idle timer stays quiescent.
module pwr_seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/m3_power_seq.sv
// m3_power_seq: ordered power-up/power-down of the M3 rails
// (VBATT -> 1P2 -> 0P6 up, reverse down), each step D+1 clk cycles.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset; drops all rails at once
//   bus   : m3_power_seq_if.slave (requests, step-delay config, rails, status)
// Parameters: DLY_W (delay width), DLY_RST (step delay after reset).
// Optional feature macro M3_PWR_SEQ_RESET_EN adds bus.m3_reset and the REL
// state that holds the M3 in reset for one extra step after 0P6 comes up.
// All outputs are registered from the next-state value.
module m3_power_seq
    import m3_power_seq_pkg::*;
#(
    parameter int unsigned      DLY_W   = 16,
    parameter logic [DLY_W-1:0] DLY_RST = DLY_W'(DLY_RST_DEF)
) (
    input logic           clk,
    input logic           reset,
    m3_power_seq_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [DLY_W-1:0] dly_cfg;
    logic [DLY_W-1:0] dly_act;
    logic             on_req;
    logic             off_req;
    logic             step_done;
    logic             leave_idle;
    logic             tmr_load;
    logic [DLY_W-1:0] tmr_val;
    rails_t           rails_q;
    logic             busy_q;
    logic             pwr_good_q;
    logic             done_q;

    // Off wins when both requests arrive together.
    assign off_req = bus.pwr_off_req;
    assign on_req  = bus.pwr_on_req & ~bus.pwr_off_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (on_req) state_nxt = ST_UP_VB;
            end
            ST_UP_VB: begin
                if (off_req)        state_nxt = ST_DN_VB;
                else if (step_done) state_nxt = ST_UP_12;
            end
            ST_UP_12: begin
                if (off_req)        state_nxt = ST_DN_12;
                else if (step_done) state_nxt = ST_UP_06;
            end
            ST_UP_06: begin
                if (off_req)        state_nxt = ST_DN_06;
`ifdef M3_PWR_SEQ_RESET_EN
                else if (step_done) state_nxt = ST_REL;
`else
                else if (step_done) state_nxt = ST_ON;
`endif
            end
`ifdef M3_PWR_SEQ_RESET_EN
            ST_REL: begin
                if (off_req)        state_nxt = ST_DN_06;
                else if (step_done) state_nxt = ST_ON;
            end
`endif
            ST_ON: begin
                if (off_req) state_nxt = ST_DN_06;
            end
            ST_DN_06: begin
                if (step_done) state_nxt = ST_DN_12;
            end
            ST_DN_12: begin
                if (step_done) state_nxt = ST_DN_VB;
            end
            ST_DN_VB: begin
                if (step_done) state_nxt = ST_OFF;
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

    // The active delay is captured only when a sequence starts; the first
    // step of that sequence must see the fresh value, so it bypasses dly_act.
    always_comb begin
        leave_idle = is_idle(state) && (state_nxt != state);
        tmr_load   = (state_nxt != state) && !is_idle(state_nxt);
        tmr_val    = leave_idle ? dly_cfg : dly_act;
    end

    pwr_seq_timer #(
        .W (DLY_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (step_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_cfg <= DLY_RST;
            dly_act <= DLY_RST;
        end else begin
            if (bus.cfg_we) dly_cfg <= bus.cfg_dly;
            if (leave_idle) dly_act <= dly_cfg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rails_q    <= '0;
            busy_q     <= 1'b0;
            pwr_good_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rails_q    <= rails_of(state_nxt);
            busy_q     <= !is_idle(state_nxt);
            pwr_good_q <= (state_nxt == ST_ON);
            done_q     <= (state_nxt != state) && is_idle(state_nxt);
        end
    end

`ifdef M3_PWR_SEQ_RESET_EN
    logic m3_reset_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m3_reset_q <= 1'b1;
        end else begin
            m3_reset_q <= (state_nxt != ST_ON);
        end
    end

    assign bus.m3_reset = m3_reset_q;
`endif

    assign bus.vbatt_sw = rails_q.vbatt;
    assign bus.v1p2_sw  = rails_q.v1p2;
    assign bus.v0p6_sw  = rails_q.v0p6;
    assign bus.busy     = busy_q;
    assign bus.pwr_good = pwr_good_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_m3_power_seq.sv
// tb_m3_power_seq: scoreboard bench for m3_power_seq.
// Cycle k is the clock period following the k-th rising edge; a request
// driven during cycle n is sampled at the edge that ends it. Stimulus tasks
// push (cycle, signal, value) expectations derived from the sequencing
// latencies; a negedge process pops and compares the ones due.
module tb_m3_power_seq;

    localparam int SIG_VB   = 0;
    localparam int SIG_12   = 1;
    localparam int SIG_06   = 2;
    localparam int SIG_BUSY = 3;
    localparam int SIG_PG   = 4;
    localparam int SIG_DONE = 5;
    localparam int SIG_M3R  = 6;

    typedef struct {
        int unsigned cyc;
        string       tag;
        int          sig;
        logic        val;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_err;
    logic        chk_en;
    exp_t        sb[$];

    m3_power_seq_if #(.DLY_W(16)) bus ();

    m3_power_seq #(
        .DLY_W   (16),
        .DLY_RST (16'd1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic obs_sig(input int s);
        case (s)
            SIG_VB:   return bus.vbatt_sw;
            SIG_12:   return bus.v1p2_sw;
            SIG_06:   return bus.v0p6_sw;
            SIG_BUSY: return bus.busy;
            SIG_PG:   return bus.pwr_good;
            SIG_DONE: return bus.done;
`ifdef M3_PWR_SEQ_RESET_EN
            SIG_M3R:  return bus.m3_reset;
`endif
            default:  return 1'bx;
        endcase
    endfunction

    task automatic ex(input int unsigned c, input string tag, input int s, input logic v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rail_order",
                {31'b0, (!bus.v0p6_sw || bus.v1p2_sw) && (!bus.v1p2_sw || bus.vbatt_sw)},
                32'd1);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    chk(sb[i].tag, {31'b0, obs_sig(sb[i].sig)}, {31'b0, sb[i].val});
                    sb.delete(i);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_on();
        bus.pwr_on_req = 1'b1;
        tick();
        bus.pwr_on_req = 1'b0;
    endtask

    task automatic pulse_off();
        bus.pwr_off_req = 1'b1;
        tick();
        bus.pwr_off_req = 1'b0;
    endtask

    task automatic set_dly(input logic [15:0] d);
        bus.cfg_we  = 1'b1;
        bus.cfg_dly = d;
        tick();
        bus.cfg_we  = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        ex(cyc + 1, "rst_vb", SIG_VB, 1'b0);
        ex(cyc + 1, "rst_12", SIG_12, 1'b0);
        ex(cyc + 1, "rst_06", SIG_06, 1'b0);
        ex(cyc + 1, "rst_busy", SIG_BUSY, 1'b0);
        ex(cyc + 1, "rst_pg", SIG_PG, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Power-up from OFF, request sampled in cycle n.
    task automatic expect_up(input int unsigned n, input int unsigned d);
        int unsigned ext;
        ext = 0;
`ifdef M3_PWR_SEQ_RESET_EN
        ext = d + 1;
        ex(n + 3 + 3*d + ext, "up_m3rst_rel", SIG_M3R, 1'b1);
        ex(n + 4 + 3*d + ext, "up_m3rst_on", SIG_M3R, 1'b0);
`endif
        ex(n + 1,               "up_vb",       SIG_VB,   1'b1);
        ex(n + 1,               "up_busy",     SIG_BUSY, 1'b1);
        ex(n + 1 + d,           "up_12_pre",   SIG_12,   1'b0);
        ex(n + 2 + d,           "up_12",       SIG_12,   1'b1);
        ex(n + 2 + 2*d,         "up_06_pre",   SIG_06,   1'b0);
        ex(n + 3 + 2*d,         "up_06",       SIG_06,   1'b1);
        ex(n + 3 + 3*d + ext,   "up_pg_pre",   SIG_PG,   1'b0);
        ex(n + 4 + 3*d + ext,   "up_pg",       SIG_PG,   1'b1);
        ex(n + 4 + 3*d + ext,   "up_done",     SIG_DONE, 1'b1);
        ex(n + 4 + 3*d + ext,   "up_busy_end", SIG_BUSY, 1'b0);
        ex(n + 5 + 3*d + ext,   "up_done_end", SIG_DONE, 1'b0);
    endtask

    // Power-down from ON, request sampled in cycle n.
    task automatic expect_dn(input int unsigned n, input int unsigned d);
`ifdef M3_PWR_SEQ_RESET_EN
        ex(n + 1, "dn_m3rst", SIG_M3R, 1'b1);
`endif
        ex(n + 1,         "dn_06",       SIG_06,   1'b0);
        ex(n + 1,         "dn_pg",       SIG_PG,   1'b0);
        ex(n + 1,         "dn_busy",     SIG_BUSY, 1'b1);
        ex(n + 1 + d,     "dn_12_pre",   SIG_12,   1'b1);
        ex(n + 2 + d,     "dn_12",       SIG_12,   1'b0);
        ex(n + 2 + 2*d,   "dn_vb_pre",   SIG_VB,   1'b1);
        ex(n + 3 + 2*d,   "dn_vb",       SIG_VB,   1'b0);
        ex(n + 3 + 3*d,   "dn_done_pre", SIG_DONE, 1'b0);
        ex(n + 4 + 3*d,   "dn_done",     SIG_DONE, 1'b1);
        ex(n + 4 + 3*d,   "dn_busy_end", SIG_BUSY, 1'b0);
        ex(n + 5 + 3*d,   "dn_done_end", SIG_DONE, 1'b0);
    endtask

    initial begin
        int unsigned n;
        int unsigned m;

        chk_en          = 1'b0;
        n_vec           = 0;
        n_err           = 0;
        reset           = 1'b1;
        bus.pwr_on_req  = 1'b1;
        bus.pwr_off_req = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_dly     = '0;

        // Reset with a request held high: the request must be discarded.
        repeat (3) tick();
        reset          = 1'b0;
        bus.pwr_on_req = 1'b0;
        chk("rst_outputs",
            {26'b0, bus.vbatt_sw, bus.v1p2_sw, bus.v0p6_sw, bus.busy, bus.pwr_good, bus.done},
            32'd0);
`ifdef M3_PWR_SEQ_RESET_EN
        chk("rst_m3_reset", {31'b0, bus.m3_reset}, 32'd1);
`endif
        chk_en = 1'b1;
        for (int unsigned k = 1; k <= 3; k++) begin
            ex(cyc + k, "rst_req_vb", SIG_VB, 1'b0);
            ex(cyc + k, "rst_req_busy", SIG_BUSY, 1'b0);
        end
        repeat (4) tick();

        // D=5, reset in cycle 8 of the power-up drops all rails at once.
        set_dly(16'd5);
        n = cyc;
        ex(n + 7, "d5_12", SIG_12, 1'b1);
        ex(n + 8, "d5_12_hold", SIG_12, 1'b1);
        pulse_on();
        wait_until(n + 8);
        pulse_reset();

        // Delay register back at 1000: 1P2 must not follow at the D=5 time.
        n = cyc;
        ex(n + 1,    "dflt_vb",     SIG_VB, 1'b1);
        ex(n + 7,    "dflt_12_d5",  SIG_12, 1'b0);
        ex(n + 1001, "dflt_12_pre", SIG_12, 1'b0);
        ex(n + 1002, "dflt_12",     SIG_12, 1'b1);
        pulse_on();
        wait_until(n + 1004);
        pulse_reset();

        // D=3 full power-up; config written mid-sequence (7) must only take
        // effect for the following power-down.
        set_dly(16'd3);
        n = cyc;
        expect_up(n, 3);
        pulse_on();
        wait_until(n + 5);
        set_dly(16'd7);
        wait_until(n + 24);
        m = cyc;
        ex(m + 1, "on_ign_pg",   SIG_PG,   1'b1);
        ex(m + 2, "on_ign_busy", SIG_BUSY, 1'b0);
        pulse_on();
        tick();
        m = cyc;
        expect_dn(m, 7);
        pulse_off();
        wait_until(m + 30);

        // D=3 abort in UP_12, plus a redundant off request in DN_VB.
        set_dly(16'd3);
        n = cyc;
        ex(n + 1,  "ab_vb",       SIG_VB,   1'b1);
        ex(n + 6,  "ab_12_pre",   SIG_12,   1'b1);
        ex(n + 7,  "ab_12",       SIG_12,   1'b0);
        ex(n + 10, "ab_vb_pre",   SIG_VB,   1'b1);
        ex(n + 11, "ab_vb_off",   SIG_VB,   1'b0);
        ex(n + 14, "ab_done_pre", SIG_DONE, 1'b0);
        ex(n + 15, "ab_done",     SIG_DONE, 1'b1);
        ex(n + 15, "ab_busy",     SIG_BUSY, 1'b0);
        ex(n + 16, "ab_done_end", SIG_DONE, 1'b0);
        for (int unsigned k = 1; k <= 16; k++) ex(n + k, "ab_06_never", SIG_06, 1'b0);
        pulse_on();
        wait_until(n + 6);
        pulse_off();
        wait_until(n + 12);
        pulse_off();
        wait_until(n + 18);

        // D=0: simultaneous requests from OFF act as off (ignored in OFF).
        set_dly(16'd0);
        n = cyc;
        ex(n + 1, "both_vb",   SIG_VB,   1'b0);
        ex(n + 1, "both_busy", SIG_BUSY, 1'b0);
        ex(n + 1, "both_done", SIG_DONE, 1'b0);
        ex(n + 2, "both_vb2",  SIG_VB,   1'b0);
        ex(n + 2, "both_done2", SIG_DONE, 1'b0);
        bus.pwr_on_req  = 1'b1;
        bus.pwr_off_req = 1'b1;
        tick();
        bus.pwr_on_req  = 1'b0;
        bus.pwr_off_req = 1'b0;
        tick();

        // D=0 power-up with a second on request while busy.
        n = cyc;
        expect_up(n, 0);
        pulse_on();
        pulse_on();
        wait_until(n + 10);
        m = cyc;
        expect_dn(m, 0);
        pulse_off();
        pulse_off();
        wait_until(m + 8);

        // Full-scale delay: the first step must not end early.
        set_dly(16'hFFFF);
        n = cyc;
        ex(n + 1, "dmax_vb", SIG_VB, 1'b1);
        for (int unsigned k = 2; k <= 40; k += 2) ex(n + k, "dmax_12", SIG_12, 1'b0);
        ex(n + 40, "dmax_busy", SIG_BUSY, 1'b1);
        pulse_on();
        wait_until(n + 41);
        pulse_reset();

        repeat (3) tick();
        chk("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
